synchronization_filter: RTL
===========================

SYNCHRONIZATION_FILTER -- requirements
Module: synchronization_filter

Interface
REQ-001 The block SHALL have parameter CHAIN_DEPTH, default 3: synchronizer flop stages per channel, legal range 2 or more.
REQ-002 The block SHALL have parameter CHAIN_WIDTH, default 4: number of independent channels, legal range 1 or more.
REQ-003 The block SHALL have parameter FILTER_CYCLES, default 4: number of consecutive enabled cycles a new value must be held before it is accepted, legal range 1 or more.
REQ-004 The block SHALL have parameter RESET_VALUE, default all-zero: CHAIN_WIDTH-bit value loaded into chain, sync_o and filt_o at reset.
REQ-005 The block SHALL have port clk_dom_i, input, sys_structs::clk_domain: its clk field is the one clock; its clk_en field gates the filter only; its sync_rst field is ignored.
REQ-006 The block SHALL have port async_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port data_i, input, CHAIN_WIDTH bits: asynchronous channel inputs.
REQ-008 The block SHALL have port sync_o, output, CHAIN_WIDTH bits: last synchronizer stage, unfiltered.
REQ-009 The block SHALL have port filt_o, output, CHAIN_WIDTH bits: debounced channel state.
REQ-010 The block SHALL have port rise_o, output, CHAIN_WIDTH bits: one-cycle pulse when filt_o[i] changes from 0 to 1.
REQ-011 The block SHALL have port fall_o, output, CHAIN_WIDTH bits: one-cycle pulse when filt_o[i] changes from 1 to 0.

Function
REQ-012 The synchronizer SHALL be a CHAIN_DEPTH-stage shift of data_i, clocked every edge regardless of clk_en. A data_i value sampled at edge N SHALL appear on sync_o after edge N+CHAIN_DEPTH-1.
REQ-013 Each channel SHALL have one counter of width max(1, clog2(FILTER_CYCLES)), and channels SHALL be fully independent.
REQ-014 On an edge with clk_en=1 and sync_o[i] not equal to filt_o[i]:
- if counter[i] equals FILTER_CYCLES-1, filt_o[i] SHALL toggle and counter[i] SHALL clear to 0;
- otherwise counter[i] SHALL increment.
REQ-015 On an edge with clk_en=1 and sync_o[i] equal to filt_o[i], counter[i] SHALL clear to 0. This discards partial glitches.
REQ-016 On an edge with clk_en=0, counter[i] and filt_o[i] SHALL hold.
REQ-017 With clk_en held at 1, filt_o[i] SHALL change exactly FILTER_CYCLES edges after sync_o[i] changes, provided sync_o[i] stays stable for that interval. FILTER_CYCLES=1 gives a single registered stage with no filtering.
REQ-018 rise_o and fall_o SHALL be registered and asserted for exactly the one cycle in which filt_o shows its new value.
- They SHALL never both be high for the same channel.
- Simultaneous events on different channels SHALL each produce their own pulse.
REQ-019 The counter SHALL never exceed FILTER_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 While async_rst_n=0, without any clock edge:
- all chain stages, sync_o and filt_o SHALL equal RESET_VALUE;
- all counters SHALL be 0;
- rise_o and fall_o SHALL be 0.
REQ-021 Reset asserted mid-debounce SHALL discard the count, and no edge pulse SHALL be generated by the reset itself.
REQ-022 The first edge after async_rst_n rises SHALL perform normal operation. Deassertion SHALL be synchronous to clk; that synchronization is provided outside this block.

Configuration
REQ-023 With macro SYNC_FILTER_EDGE_EN defined, the rise_o and fall_o logic SHALL be built as specified.
REQ-024 With SYNC_FILTER_EDGE_EN undefined:
- rise_o and fall_o SHALL remain ports tied to 0, and their flops SHALL be removed;
- all other behaviour SHALL be unchanged.

Verification
REQ-025 Use CHAIN_DEPTH=3, CHAIN_WIDTH=4, FILTER_CYCLES=4, RESET_VALUE=4'b0000 and clk_en=1 unless stated otherwise.
- Reset: drive async_rst_n=0 between edges with outputs at 4'hF -> sync_o=filt_o=0 and rise_o=fall_o=0 immediately, before the next edge.
- Step: data_i[0] goes 0 to 1 before edge 10 -> sync_o[0]=1 after edge 12; filt_o[0]=1 and rise_o[0]=1 after edge 16; rise_o[0]=0 after edge 17.
- Glitch: data_i[1] is high for 3 cycles, then low -> sync_o[1] shows the 3-cycle pulse; filt_o[1] stays 0; no pulse on rise_o[1].
- Enable gating: clk_en toggles 1,0,1,0 with a step on channel 2 -> filt_o[2] changes 8 edges after sync_o[2]; the counter holds on every clk_en=0 edge.
- Simultaneous: channel 0 rises and channel 3 falls in the same cycle, from filt_o=4'b1000 -> rise_o=4'b0001 and fall_o=4'b1000 in the same single cycle; filt_o=4'b0001.
- Macro off: repeat the step scenario without SYNC_FILTER_EDGE_EN -> filt_o timing is identical; rise_o and fall_o stay 0 throughout.

Source files
------------

// File: rtl/synchronization_filter.sv
// Multi-channel synchronizer with per-channel debounce filter and registered edge pulses.
// Build option: define SYNC_FILTER_EDGE_EN to build the rise_o/fall_o pulse flops.

package sys_structs;
    typedef struct packed {
        logic clk;
        logic clk_en;
        logic sync_rst;
    } clk_domain;
endpackage

module synchronization_filter #(
    parameter int unsigned            CHAIN_DEPTH   = 3,
    parameter int unsigned            CHAIN_WIDTH   = 4,
    parameter int unsigned            FILTER_CYCLES = 4,
    parameter logic [CHAIN_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  sys_structs::clk_domain   clk_dom_i,
    input  logic                     async_rst_n,
    input  logic [CHAIN_WIDTH-1:0]   data_i,
    output logic [CHAIN_WIDTH-1:0]   sync_o,
    output logic [CHAIN_WIDTH-1:0]   filt_o,
    output logic [CHAIN_WIDTH-1:0]   rise_o,
    output logic [CHAIN_WIDTH-1:0]   fall_o
);

    localparam int unsigned      CNT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);

    logic clk;
    logic clk_en;
    logic unused_sync_rst;

    assign clk             = clk_dom_i.clk;
    assign clk_en          = clk_dom_i.clk_en;
    assign unused_sync_rst = clk_dom_i.sync_rst;

    logic [CHAIN_DEPTH-1:0][CHAIN_WIDTH-1:0] chain;
    logic [CHAIN_WIDTH-1:0][CNT_W-1:0]       cnt;
    logic [CHAIN_WIDTH-1:0][CNT_W-1:0]       cnt_nxt;
    logic [CHAIN_WIDTH-1:0]                  filt_nxt;

    // Synchronizer shift runs on every edge; clk_en only gates the filter.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            chain <= {CHAIN_DEPTH{RESET_VALUE}};
        end else begin
            chain <= {chain[CHAIN_DEPTH-2:0], data_i};
        end
    end

    assign sync_o = chain[CHAIN_DEPTH-1];

    // A channel must disagree with filt_o for FILTER_CYCLES enabled edges in a row to flip.
    always_comb begin
        cnt_nxt  = cnt;
        filt_nxt = filt_o;
        if (clk_en) begin
            for (int unsigned i = 0; i < CHAIN_WIDTH; i++) begin
                if (sync_o[i] != filt_o[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        filt_nxt[i] = ~filt_o[i];
                        cnt_nxt[i]  = '0;
                    end else begin
                        cnt_nxt[i]  = cnt[i] + CNT_W'(1);
                    end
                end else begin
                    cnt_nxt[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            cnt    <= '0;
            filt_o <= RESET_VALUE;
        end else begin
            cnt    <= cnt_nxt;
            filt_o <= filt_nxt;
        end
    end

`ifdef SYNC_FILTER_EDGE_EN
    // Pulses line up with the edge on which filt_o takes its new value.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            rise_o <= '0;
            fall_o <= '0;
        end else begin
            rise_o <= filt_nxt & ~filt_o;
            fall_o <= ~filt_nxt & filt_o;
        end
    end
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

endmodule
